// File: rtl/lc3_mem_arbiter.sv
`timescale 1ns/1ps
// lc3_mem_arbiter: round-robin sequencer for the shared LC-3 memory.
// Produces the R (ready) pulse for the CPU and an ack for the loader.
module lc3_mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mio_en,
  input  logic              cpu_r_w,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int CW =
    (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    CPU_ACC,
    LDR_ACC,
    CPU_DONE,
    LDR_DONE
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  req_t              req_q;
  req_t              req_in;
  logic              owner_q;
  logic              last_owner;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ldr_rdata_q;
  logic              cpu_win;
  logic              ldr_win;
  logic              grant;
  logic              in_acc;
  logic              last_beat;

  // On a tie the port that did not own the last access wins.
  assign cpu_win = cpu_mio_en &
                   (~ldr_req | last_owner);
  assign ldr_win = ldr_req &
                   (~cpu_mio_en | ~last_owner);

  assign in_acc    = (state == CPU_ACC) |
                     (state == LDR_ACC);
  assign last_beat = in_acc & (cnt == '0);
  assign grant     = (state == IDLE) &
                     (cpu_win | ldr_win);

  always_comb begin
    req_in = '{
      we:    cpu_r_w,
      addr:  cpu_addr,
      wdata: cpu_wdata
    };
    if (ldr_win) begin
      req_in = '{
        we:    ldr_we,
        addr:  ldr_addr,
        wdata: ldr_wdata
      };
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          cpu_win: state_nxt = CPU_ACC;
          ldr_win: state_nxt = LDR_ACC;
          default: state_nxt = IDLE;
        endcase
      end
      CPU_ACC: begin
        if (cnt == '0) state_nxt = CPU_DONE;
      end
      LDR_ACC: begin
        if (cnt == '0) state_nxt = LDR_DONE;
      end
      CPU_DONE: state_nxt = IDLE;
      LDR_DONE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      req_q      <= '0;
      owner_q    <= 1'b0;
      last_owner <= 1'b1;
    end else if (grant) begin
      cnt        <= CNT_INIT;
      req_q      <= req_in;
      owner_q    <= ldr_win;
      last_owner <= ldr_win;
    end else if (in_acc && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Read data is captured on the edge that ends the access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else if (last_beat && !req_q.we) begin
      if (state == CPU_ACC) cpu_rdata_q <= mem_rdata;
      if (state == LDR_ACC) ldr_rdata_q <= mem_rdata;
    end
  end

  assign mem_cs    = in_acc;
  assign mem_we    = in_acc & req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign cpu_ready = (state == CPU_DONE);
  assign ldr_ack   = (state == LDR_DONE);
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign busy      = (state != IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
`timescale 1ns/1ps
// tb_lc3_mem_arbiter: vector table plus scoreboard of completions,
// with hand sequences for back-to-back, mid-access reset, latency 1.
module tb_lc3_mem_arbiter;

  localparam int ML = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_mio_en = 1'b0, cpu_r_w = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic        cpu_ready;
  logic        ldr_req = 1'b0, ldr_we = 1'b0;
  logic [15:0] ldr_addr = '0, ldr_wdata = '0, ldr_rdata;
  logic        ldr_ack;
  logic        mem_cs, mem_we, busy, owner;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic        cpu_mio_en1 = 1'b0;
  logic [15:0] cpu_addr1 = '0;
  logic [15:0] cpu_rdata1, ldr_rdata1;
  logic        cpu_ready1, ldr_ack1;
  logic        mem_cs1, mem_we1, busy1, owner1;
  logic [15:0] mem_addr1, mem_wdata1, mem_rdata1;

  lc3_mem_arbiter #(.MEM_LATENCY(ML)) dut (
    .clk(clk), .reset(reset),
    .cpu_mio_en(cpu_mio_en), .cpu_r_w(cpu_r_w),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .ldr_req(ldr_req), .ldr_we(ldr_we),
    .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  lc3_mem_arbiter #(.MEM_LATENCY(1)) u1 (
    .clk(clk), .reset(reset),
    .cpu_mio_en(cpu_mio_en1), .cpu_r_w(1'b0),
    .cpu_addr(cpu_addr1), .cpu_wdata(16'h0),
    .cpu_rdata(cpu_rdata1), .cpu_ready(cpu_ready1),
    .ldr_req(1'b0), .ldr_we(1'b0),
    .ldr_addr(16'h0), .ldr_wdata(16'h0),
    .ldr_rdata(ldr_rdata1), .ldr_ack(ldr_ack1),
    .mem_cs(mem_cs1), .mem_we(mem_we1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1), .owner(owner1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [15:0] mem    [0:65535];
  logic [15:0] shadow [0:65535];
  assign mem_rdata  = mem[mem_addr];
  assign mem_rdata1 = mem_addr1 ^ 16'h5A5A;
  always @(posedge clk) if (mem_cs && mem_we) mem[mem_addr] = mem_wdata;

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    bit rst;
    bit c_en; bit c_we; logic [15:0] c_a; logic [15:0] c_d;
    bit l_en; bit l_we; logic [15:0] l_a; logic [15:0] l_d;
    bit first;
  } vec_t;

  exp_t        sbq[$];
  logic [15:0] last_rd [2];
  int          n_tests = 0, n_fail = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic fail(string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic void push(bit port, bit we, logic [15:0] a, logic [15:0] d);
    exp_t e;
    e.port = port; e.we = we; e.addr = a;
    e.data = we ? d : shadow[a];
    if (we) shadow[a] = d;
    sbq.push_back(e);
  endfunction

  // Scoreboard: every ready/ack pops the next expected access.
  int          cs_n = 0;
  logic [15:0] a0, d0;
  logic        w0;
  exp_t        e;
  always @(negedge clk) begin
    if (!reset) begin
      cs_n = 0;
    end else begin
      if (mem_cs) begin
        if (cs_n == 0) begin
          a0 = mem_addr; d0 = mem_wdata; w0 = mem_we;
        end else begin
          check("mem_stable", {mem_we, mem_addr, mem_wdata}, {w0, a0, d0});
        end
        cs_n++;
      end
      if (cpu_ready && ldr_ack) fail("both_pulse");
      if (cpu_ready || ldr_ack) begin
        if (sbq.size() == 0) begin
          fail("spurious_pulse");
        end else begin
          e = sbq.pop_front();
          check("port", ldr_ack, e.port);
          check("owner", owner, e.port);
          check("cs_len", cs_n, ML);
          check("mem_addr", a0, e.addr);
          check("mem_we", w0, e.we);
          if (e.we) begin
            check("mem_wdata", d0, e.data);
          end else begin
            last_rd[e.port] = e.data;
          end
          check("rdata", e.port ? ldr_rdata : cpu_rdata, last_rd[e.port]);
        end
        cs_n = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_vec(vec_t v);
    int t0, ta, tb, np;
    if (v.rst) do_reset();
    @(negedge clk);
    if (v.c_en && v.l_en && v.first) begin
      push(1, v.l_we, v.l_a, v.l_d);
      push(0, v.c_we, v.c_a, v.c_d);
    end else begin
      if (v.c_en) push(0, v.c_we, v.c_a, v.c_d);
      if (v.l_en) push(1, v.l_we, v.l_a, v.l_d);
    end
    cpu_mio_en = v.c_en; cpu_r_w = v.c_we;
    cpu_addr = v.c_a; cpu_wdata = v.c_d;
    ldr_req = v.l_en; ldr_we = v.l_we;
    ldr_addr = v.l_a; ldr_wdata = v.l_d;
    t0 = cyc; np = 0; ta = 0; tb = 0;
    for (int i = 0; i < 40 && (cpu_mio_en || ldr_req); i++) begin
      @(negedge clk);
      if (cpu_ready || ldr_ack) begin
        np++;
        if (np == 1) ta = cyc;
        else tb = cyc;
      end
      if (cpu_ready) cpu_mio_en = 1'b0;
      if (ldr_ack) ldr_req = 1'b0;
    end
    if (cpu_mio_en || ldr_req) begin
      fail("vec_timeout");
      cpu_mio_en = 1'b0; ldr_req = 1'b0;
      sbq.delete();
    end
    check("lat_first", ta - t0, ML + 1);
    if (v.c_en && v.l_en) check("lat_second", tb - ta, ML + 2);
  endtask

  vec_t tv [8];
  vec_t vx;

  initial begin
    int t0, t1, t2, k, nack, nrdy;

    // rst, cpu{en,we,a,d}, ldr{en,we,a,d}, first(1=loader)
    tv[0] = '{1, 1,0,16'h3000,16'h0,    0,0,16'h0,16'h0,    0};
    tv[1] = '{0, 1,1,16'h3001,16'h1234, 0,0,16'h0,16'h0,    0};
    tv[2] = '{1, 1,0,16'h3001,16'h0,    1,0,16'h3000,16'h0, 0};
    tv[3] = '{0, 1,1,16'h3002,16'h5555, 1,0,16'h3001,16'h0, 0};
    tv[4] = '{0, 0,0,16'h0,16'h0,       1,1,16'h3003,16'h7777, 1};
    tv[5] = '{0, 1,0,16'h3003,16'h0,    1,1,16'h3003,16'h8888, 0};
    tv[6] = '{0, 0,0,16'h0,16'h0,       1,0,16'h3003,16'h0, 1};
    tv[7] = '{0, 1,0,16'h3002,16'h0,    0,0,16'h0,16'h0,    0};

    mem[16'h3000] = 16'hBEEF;
    shadow[16'h3000] = 16'hBEEF;
    last_rd[0] = '0;
    last_rd[1] = '0;

    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data", {cpu_rdata, ldr_rdata, mem_addr, mem_wdata}, 64'h0);
    check("rst_ctl",
          {cpu_ready, ldr_ack, mem_cs, mem_we, busy, owner}, 6'h0);
    check("rst_u1", {cpu_rdata1, cpu_ready1, mem_cs1}, 18'h0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(tv[i]);

    // Loader holds its request across two back-to-back writes.
    @(negedge clk);
    push(1, 1, 16'h3000, 16'h0001);
    push(1, 1, 16'h3001, 16'h0002);
    ldr_req = 1'b1; ldr_we = 1'b1;
    ldr_addr = 16'h3000; ldr_wdata = 16'h0001;
    t0 = cyc; t1 = 0; t2 = 0; nack = 0;
    for (int i = 0; i < 40 && ldr_req; i++) begin
      @(negedge clk);
      if (ldr_ack) begin
        nack++;
        if (nack == 1) begin
          t1 = cyc;
          ldr_addr = 16'h3001; ldr_wdata = 16'h0002;
        end else begin
          t2 = cyc;
          ldr_req = 1'b0;
        end
      end
    end
    if (ldr_req) begin
      fail("b2b_timeout");
      ldr_req = 1'b0;
    end
    repeat (ML + 3) @(negedge clk);
    check("b2b_lat1", t1 - t0, ML + 1);
    check("b2b_gap", t2 - t1, ML + 2);
    check("b2b_drained", sbq.size(), 0);
    vx = '{0, 1,0,16'h3001,16'h0, 1,0,16'h3000,16'h0, 0};
    run_vec(vx);

    // Reset arriving in the second cycle of a CPU read.
    @(negedge clk);
    push(0, 0, 16'h3001, 16'h0);
    cpu_mio_en = 1'b1; cpu_r_w = 1'b0; cpu_addr = 16'h3001;
    k = 0;
    for (int i = 0; i < 20 && k < 2; i++) begin
      @(negedge clk);
      if (mem_cs) k++;
    end
    check("abort_reached", k, 2);
    #2 reset = 1'b0;
    #1;
    check("abort_async", {mem_cs, mem_we, busy, cpu_ready}, 4'h0);
    check("abort_rdata", cpu_rdata, 16'h0);
    sbq.delete();
    last_rd[0] = '0;
    last_rd[1] = '0;
    cpu_mio_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    nrdy = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cpu_ready) nrdy++;
    end
    check("abort_no_ready", nrdy, 0);
    check("abort_idle", busy, 1'b0);

    // Latency-1 instance: one cs cycle, ready right after.
    @(negedge clk);
    cpu_mio_en1 = 1'b1; cpu_addr1 = 16'h0042;
    t0 = cyc; t1 = 0; k = 0;
    for (int i = 0; i < 10 && cpu_mio_en1; i++) begin
      @(negedge clk);
      if (mem_cs1) k++;
      if (cpu_ready1) begin
        t1 = cyc;
        cpu_mio_en1 = 1'b0;
      end
    end
    if (cpu_mio_en1) begin
      fail("ml1_timeout");
      cpu_mio_en1 = 1'b0;
    end
    check("ml1_cs_len", k, 1);
    check("ml1_lat", t1 - t0, 2);
    check("ml1_rdata", cpu_rdata1, 16'h5A18);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
- Sequences all accesses to the shared single-port LC-3 memory and generates the R (ready_bit) condition consumed by control_logic.
- Arbitrates between the CPU port (driven by the control unit's mio_en and r_w plus the MAR/MDR datapath) and a loader port, which preloads programs (e.g. bubble sort) and inspects results.
- Sits between the control/datapath and the memory array.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MEM_LATENCY, 3, cycles the memory needs per access (legal range >= 1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_mio_en  in  1  CPU memory request, held high until cpu_ready is seen
cpu_r_w  in  1  1 = write, 0 = read (LC-3 R.W)
cpu_addr  in  ADDR_W  address from MAR
cpu_wdata  in  DATA_W  write data from MDR
cpu_rdata  out  DATA_W  registered read data to MDR
cpu_ready  out  1  ready_bit (R) to control_logic, one-cycle pulse
ldr_req  in  1  loader request, held high until ldr_ack
ldr_we  in  1  1 = write, 0 = read
ldr_addr  in  ADDR_W  loader address
ldr_wdata  in  DATA_W  loader write data
ldr_rdata  out  DATA_W  registered read data to loader
ldr_ack  out  1  loader completion, one-cycle pulse
mem_cs  out  1  memory chip select
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid at end of MEM_LATENCY-th cs cycle
busy  out  1  high in any state other than IDLE
owner  out  1  0 = CPU, 1 = loader (owner of current or last access)

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE; latency counter = 0; last_owner = 1, so the CPU wins the first tie.
  - All outputs are 0, including both rdata registers.
  - mem_cs and mem_we drop immediately, without waiting for a clock edge.
- States are IDLE, CPU_ACC, LDR_ACC, CPU_DONE, LDR_DONE.
- IDLE:
  - Only cpu_mio_en → CPU_ACC.
  - Only ldr_req → LDR_ACC.
  - Both asserted → grant the requester that is not last_owner (round-robin).
  - Neither asserted → stay in IDLE.
  - On grant, latch addr, wdata and write flag into internal registers, set the counter to MEM_LATENCY-1, and update owner/last_owner.
- x_ACC:
  - mem_cs = 1. mem_we = latched write flag. mem_addr and mem_wdata come from the latched registers and are stable for the whole access.
  - Counter decrements each cycle. When counter == 0, move to x_DONE at the next edge.
  - For reads, capture mem_rdata into cpu_rdata or ldr_rdata on that same edge.
  - Total mem_cs high time is exactly MEM_LATENCY cycles.
- x_DONE:
  - mem_cs = 0. cpu_ready (or ldr_ack) = 1 for exactly this one cycle.
  - Next state is always IDLE. Requests are not sampled here; this is the recovery cycle that stops a still-held request from re-triggering.
- Latency: with the request sampled in IDLE at edge k, ACC occupies cycles k+1 … k+MEM_LATENCY, and the ready/ack pulse is high in cycle k+MEM_LATENCY+1.
- Back-to-back: the minimum period between grants is MEM_LATENCY+2 cycles.
- Writes leave the corresponding rdata register unchanged. rdata holds its value until the next read by that port completes.
- A request deasserted mid-access does not abort it: the access completes and ready/ack still pulses.
- A request held into IDLE after DONE is treated as a new request (the requester must drop it after ready).
- The other port's request is stalled, never dropped, while an access is in progress.
- busy = (state != IDLE).
- Outputs are driven only by registers or decode of state; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then a CPU read: cpu_addr=16'h3000 with the memory model returning 16'hBEEF, cpu_r_w=0 → mem_cs high exactly 3 cycles with mem_addr=3000, mem_we=0; cpu_ready pulses once at edge+4; cpu_rdata=BEEF.
- CPU write: addr 16'h3001, data 16'h1234, cpu_r_w=1 → mem_we=1 for 3 cycles with mem_wdata=1234; cpu_ready pulses; cpu_rdata keeps its previous value BEEF.
- Loader and CPU request in the same cycle right after reset → CPU is granted first (owner=0), then the loader (owner=1); ldr_ack follows cpu_ready after 5 cycles. A repeated simultaneous request grants the CPU again (alternation).
- Loader writes 16'h0001, 16'h0002 to x3000/x3001 back-to-back while holding ldr_req → two ldr_ack pulses 5 cycles apart; there is no duplicate access from the held request during the DONE cycle.
- Assert reset mid-CPU_ACC (second cs cycle) → mem_cs, busy and cpu_ready go 0 immediately; after release the FSM is in IDLE and cpu_ready never pulses for the aborted access.
- MEM_LATENCY=1 build: CPU read → mem_cs high for 1 cycle, cpu_ready high in the following cycle, total 2 cycles from sample to ready.
